// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - one master's request/acknowledge port into the memory arbiter
// The master drives the held command; the arbiter answers with a one-cycle ack and read data.
interface mem_arbiter_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output ack,
      output rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master arbiter onto a single synchronous RAM port
// One access per three cycles: sample/grant in IDLE, drive RAM in ISSUE, ack in RESP.
module mem_arbiter #(
   parameter int ADDR_W     = 30,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_arbiter_if.slave      m0,
   mem_arbiter_if.slave      m1,
   output logic              ram_wren,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   logic [1:0]        state;
   logic              gnt;
   logic              last_grant;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic any_req;
   logic winner;
   logic in_issue;
   logic in_resp;
   logic ack0;
   logic ack1;

   // Contention goes to master 0 in fixed mode, otherwise to whoever was not granted last.
   always_comb begin
      any_req = m0.req | m1.req;
      winner  = 1'b0;
      if (m0.req && m1.req) begin
         winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
      end else if (m1.req) begin
         winner = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  state      <= S_ISSUE;
                  gnt        <= winner;
                  last_grant <= winner;
                  cmd_we     <= winner ? m1.we    : m0.we;
                  cmd_addr   <= winner ? m1.addr  : m0.addr;
                  cmd_wdata  <= winner ? m1.wdata : m0.wdata;
               end
            end
            S_ISSUE: state <= S_RESP;
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Strobes come from registered state only, so an async reset in ISSUE kills the write at once.
   always_comb begin
      in_issue    = (state == S_ISSUE);
      in_resp     = (state == S_RESP);
      busy        = (state != S_IDLE);
      ram_wren    = in_issue & cmd_we;
      ram_address = cmd_addr;
      ram_data    = cmd_wdata;
      ack0        = in_resp & ~gnt;
      ack1        = in_resp & gnt;
   end

   assign m0.ack   = ack0;
   assign m1.ack   = ack1;
   assign m0.rdata = (ack0 && !cmd_we) ? ram_q : '0;
   assign m1.rdata = (ack1 && !cmd_we) ? ram_q : '0;
endmodule
